// File: rtl/shifter_operand_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : shifter_operand_pipe
// Purpose  : Pipelined ARM data-processing operand-2 unit. Produces the
//            shifter_operand and shifter carry-out for immediate-rotate,
//            immediate-shift (incl. RRX) and register-shift encodings, with a
//            valid/ready handshake on both sides so EX can stall it.
// Ports    : clk        - clock, rising edge
//            reset      - asynchronous reset, active-high
//            in_valid   - instr/rm_val/rs_val/c_in valid
//            in_ready   - unit can accept this cycle
//            instr      - instruction word (bits [25] and [11:0] used)
//            rm_val     - Rm operand
//            rs_val     - Rs[7:0], register-specified shift amount
//            c_in       - current CPSR C flag
//            out_valid  - op2/c_out/out_err valid
//            out_ready  - consumer accepts this cycle
//            op2        - shifter_operand
//            c_out      - shifter_carry_out
//            out_err    - instr[25]=0, instr[7]=1, instr[4]=1 (not a shifter form)
// Params   : DATA_W (16..64, power of two), STAGES (1 or 2)
// Revision : 1.0 - initial release
// ============================================================================
module shifter_operand_pipe #(
  parameter int DATA_W = 32,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] rm_val,
  input  logic [7:0]        rs_val,
  input  logic              c_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] op2,
  output logic              c_out,
  output logic              out_err
);

  localparam int AMT_W = $clog2(DATA_W);
  localparam logic [7:0] c_width = 8'(DATA_W);

  // Shifter operation selected for the barrel stage
  localparam logic [1:0] c_op_lsl = 2'd0;
  localparam logic [1:0] c_op_lsr = 2'd1;
  localparam logic [1:0] c_op_asr = 2'd2;
  localparam logic [1:0] c_op_ror = 2'd3;

  // How the final result is formed
  localparam logic [1:0] c_res_shift = 2'd0;  // barrel-shifter output
  localparam logic [1:0] c_res_zero  = 2'd1;  // shifted completely out
  localparam logic [1:0] c_res_sign  = 2'd2;  // ASR saturated: sign fill
  localparam logic [1:0] c_res_rrx   = 2'd3;  // {c_in, src[MSB:1]}

  // Where the carry comes from
  localparam logic [2:0] c_c_cin  = 3'd0;  // unchanged CPSR C
  localparam logic [2:0] c_c_bit  = 3'd1;  // last bit shifted out
  localparam logic [2:0] c_c_rmsb = 3'd2;  // result MSB (rotates)
  localparam logic [2:0] c_c_smsb = 3'd3;  // source MSB
  localparam logic [2:0] c_c_slsb = 3'd4;  // source LSB
  localparam logic [2:0] c_c_zero = 3'd5;  // constant zero

  // Instruction fields outside [25] and [11:0] are not used by this unit
  logic w_unused;
  assign w_unused = &{1'b0, instr[31:26], instr[24:12]};

  // --------------------------------------------------------------------------
  // Decode: reduce every encoding to {source, op, amount, result mode, carry
  // mode}. Amounts >= DATA_W never reach the barrel shifter; they are folded
  // into the result/carry modes here.
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] w_dec_src;
  logic [1:0]        w_dec_op;
  logic [AMT_W-1:0]  w_dec_amt;
  logic [1:0]        w_dec_rmode;
  logic [2:0]        w_dec_cmode;
  logic              w_dec_err;
  logic [7:0]        w_n;
  logic              w_imm_n_zero;
  logic              w_is_rrx;
  logic [AMT_W-1:0]  w_rot_amt;

  assign w_imm_n_zero = (instr[11:7] == 5'd0);
  assign w_is_rrx     = !instr[4] && w_imm_n_zero && (instr[6:5] == c_op_ror);
  // 2*rot, reduced modulo DATA_W by truncation
  assign w_rot_amt    = AMT_W'({instr[11:8], 1'b0});

  // Immediate LSR/ASR #0 encode a shift by the full width
  always_comb begin
    w_n = {3'b000, instr[11:7]};
    if (instr[4]) begin
      w_n = rs_val;
    end else if (w_imm_n_zero && (instr[6:5] == c_op_lsr || instr[6:5] == c_op_asr)) begin
      w_n = c_width;
    end
  end

  always_comb begin
    w_dec_src   = rm_val;
    w_dec_op    = c_op_lsl;
    w_dec_amt   = '0;
    w_dec_rmode = c_res_shift;
    w_dec_cmode = c_c_cin;
    w_dec_err   = 1'b0;
    if (instr[25]) begin
      w_dec_src   = {{(DATA_W-8){1'b0}}, instr[7:0]};
      w_dec_op    = c_op_ror;
      w_dec_amt   = w_rot_amt;
      w_dec_cmode = (instr[11:8] == 4'd0) ? c_c_cin : c_c_rmsb;
    end else if (instr[7] && instr[4]) begin
      w_dec_err = 1'b1;             // pass Rm / c_in through, flag the error
    end else if (w_is_rrx) begin
      w_dec_rmode = c_res_rrx;
      w_dec_cmode = c_c_slsb;
    end else if (w_n != 8'd0) begin // n == 0 keeps the pass-through defaults
      case (instr[6:5])
        c_op_lsl: begin
          if (w_n < c_width) begin
            w_dec_op    = c_op_lsl;
            w_dec_amt   = w_n[AMT_W-1:0];
            w_dec_cmode = c_c_bit;
          end else begin
            w_dec_rmode = c_res_zero;
            w_dec_cmode = (w_n == c_width) ? c_c_slsb : c_c_zero;
          end
        end
        c_op_lsr: begin
          if (w_n < c_width) begin
            w_dec_op    = c_op_lsr;
            w_dec_amt   = w_n[AMT_W-1:0];
            w_dec_cmode = c_c_bit;
          end else begin
            w_dec_rmode = c_res_zero;
            w_dec_cmode = (w_n == c_width) ? c_c_smsb : c_c_zero;
          end
        end
        c_op_asr: begin
          if (w_n < c_width) begin
            w_dec_op    = c_op_asr;
            w_dec_amt   = w_n[AMT_W-1:0];
            w_dec_cmode = c_c_bit;
          end else begin
            w_dec_rmode = c_res_sign;
            w_dec_cmode = c_c_smsb;
          end
        end
        default: begin
          // Rotates only see n mod DATA_W; a multiple of DATA_W leaves Rm
          // intact and the carry equals its MSB, which c_c_rmsb yields too.
          w_dec_op    = c_op_ror;
          w_dec_amt   = w_n[AMT_W-1:0];
          w_dec_cmode = c_c_rmsb;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Pipeline front end: either a decode register stage (STAGES=2) or direct
  // feed-through (STAGES=1). The output register is always the last stage.
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] w_ex_src;
  logic [1:0]        w_ex_op;
  logic [AMT_W-1:0]  w_ex_amt;
  logic [1:0]        w_ex_rmode;
  logic [2:0]        w_ex_cmode;
  logic              w_ex_err;
  logic              w_ex_cin;
  logic              w_up_valid;
  logic              w_out_take;

  // Output register can load when empty or being drained this cycle
  assign w_out_take = !out_valid || out_ready;

  generate
    if (STAGES == 2) begin : g_two_stage
      logic              r_s1_valid;
      logic [DATA_W-1:0] r_s1_src;
      logic [1:0]        r_s1_op;
      logic [AMT_W-1:0]  r_s1_amt;
      logic [1:0]        r_s1_rmode;
      logic [2:0]        r_s1_cmode;
      logic              r_s1_err;
      logic              r_s1_cin;

      assign in_ready = !reset && (!r_s1_valid || w_out_take);

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_s1_valid <= 1'b0;
          r_s1_src   <= '0;
          r_s1_op    <= '0;
          r_s1_amt   <= '0;
          r_s1_rmode <= '0;
          r_s1_cmode <= '0;
          r_s1_err   <= 1'b0;
          r_s1_cin   <= 1'b0;
        end else if (in_ready) begin
          r_s1_valid <= in_valid;
          if (in_valid) begin
            r_s1_src   <= w_dec_src;
            r_s1_op    <= w_dec_op;
            r_s1_amt   <= w_dec_amt;
            r_s1_rmode <= w_dec_rmode;
            r_s1_cmode <= w_dec_cmode;
            r_s1_err   <= w_dec_err;
            r_s1_cin   <= c_in;
          end
        end
      end

      assign w_up_valid = r_s1_valid;
      assign w_ex_src   = r_s1_src;
      assign w_ex_op    = r_s1_op;
      assign w_ex_amt   = r_s1_amt;
      assign w_ex_rmode = r_s1_rmode;
      assign w_ex_cmode = r_s1_cmode;
      assign w_ex_err   = r_s1_err;
      assign w_ex_cin   = r_s1_cin;
    end else begin : g_one_stage
      assign in_ready   = !reset && w_out_take;
      assign w_up_valid = in_valid;
      assign w_ex_src   = w_dec_src;
      assign w_ex_op    = w_dec_op;
      assign w_ex_amt   = w_dec_amt;
      assign w_ex_rmode = w_dec_rmode;
      assign w_ex_cmode = w_dec_cmode;
      assign w_ex_err   = w_dec_err;
      assign w_ex_cin   = c_in;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Barrel shifter. Each shift is widened by one bit so the last bit shifted
  // out lands in the extra position (carry for amounts 1..DATA_W-1).
  // --------------------------------------------------------------------------
  logic [DATA_W:0]   w_lsl;
  logic [DATA_W:0]   w_lsr;
  logic [DATA_W:0]   w_asr;
  logic [DATA_W-1:0] w_ror;
  logic [DATA_W-1:0] w_shift;
  logic              w_shift_bit;
  logic [DATA_W-1:0] w_res;
  logic              w_carry;

  assign w_lsl = {1'b0, w_ex_src} << w_ex_amt;
  assign w_lsr = {w_ex_src, 1'b0} >> w_ex_amt;
  assign w_asr = $unsigned($signed({w_ex_src, 1'b0}) >>> w_ex_amt);
  assign w_ror = DATA_W'({w_ex_src, w_ex_src} >> w_ex_amt);

  always_comb begin
    w_shift     = w_ror;
    w_shift_bit = w_ror[DATA_W-1];
    case (w_ex_op)
      c_op_lsl: begin w_shift = w_lsl[DATA_W-1:0]; w_shift_bit = w_lsl[DATA_W]; end
      c_op_lsr: begin w_shift = w_lsr[DATA_W:1];   w_shift_bit = w_lsr[0];      end
      c_op_asr: begin w_shift = w_asr[DATA_W:1];   w_shift_bit = w_asr[0];      end
      default:  begin w_shift = w_ror;             w_shift_bit = w_ror[DATA_W-1]; end
    endcase
  end

  always_comb begin
    w_res = w_shift;
    case (w_ex_rmode)
      c_res_zero: w_res = '0;
      c_res_sign: w_res = {DATA_W{w_ex_src[DATA_W-1]}};
      c_res_rrx:  w_res = {w_ex_cin, w_ex_src[DATA_W-1:1]};
      default:    w_res = w_shift;
    endcase
  end

  always_comb begin
    w_carry = w_ex_cin;
    case (w_ex_cmode)
      c_c_bit:  w_carry = w_shift_bit;
      c_c_rmsb: w_carry = w_res[DATA_W-1];
      c_c_smsb: w_carry = w_ex_src[DATA_W-1];
      c_c_slsb: w_carry = w_ex_src[0];
      c_c_zero: w_carry = 1'b0;
      default:  w_carry = w_ex_cin;
    endcase
  end

  // Output register: holds while out_valid & !out_ready
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      op2       <= '0;
      c_out     <= 1'b0;
      out_err   <= 1'b0;
    end else if (w_out_take) begin
      out_valid <= w_up_valid;
      if (w_up_valid) begin
        op2     <= w_res;
        c_out   <= w_carry;
        out_err <= w_ex_err;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shifter_operand_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_shifter_operand_pipe
// Purpose  : Directed self-checking bench for shifter_operand_pipe. Four
//            instances: 32b/1 stage, 32b/2 stages, 16b/1 stage, 64b/2 stages.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shifter_operand_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] instr;
  logic [7:0]  rs;
  logic        cin;
  logic [31:0] rm32;
  logic [15:0] rm16;
  logic [63:0] rm64;

  logic d1_iv, d1_ir, d1_ov, d1_or, d1_c, d1_e;
  logic d2_iv, d2_ir, d2_ov, d2_or, d2_c, d2_e;
  logic d16_iv, d16_ir, d16_ov, d16_or, d16_c, d16_e;
  logic d64_iv, d64_ir, d64_ov, d64_or, d64_c, d64_e;
  logic [31:0] d1_op2, d2_op2;
  logic [15:0] d16_op2;
  logic [63:0] d64_op2;

  int total = 0;
  int bad   = 0;

  shifter_operand_pipe #(.DATA_W(32), .STAGES(1)) u_d1 (
    .clk(clk), .reset(reset), .in_valid(d1_iv), .in_ready(d1_ir), .instr(instr),
    .rm_val(rm32), .rs_val(rs), .c_in(cin), .out_valid(d1_ov), .out_ready(d1_or),
    .op2(d1_op2), .c_out(d1_c), .out_err(d1_e));

  shifter_operand_pipe #(.DATA_W(32), .STAGES(2)) u_d2 (
    .clk(clk), .reset(reset), .in_valid(d2_iv), .in_ready(d2_ir), .instr(instr),
    .rm_val(rm32), .rs_val(rs), .c_in(cin), .out_valid(d2_ov), .out_ready(d2_or),
    .op2(d2_op2), .c_out(d2_c), .out_err(d2_e));

  shifter_operand_pipe #(.DATA_W(16), .STAGES(1)) u_d16 (
    .clk(clk), .reset(reset), .in_valid(d16_iv), .in_ready(d16_ir), .instr(instr),
    .rm_val(rm16), .rs_val(rs), .c_in(cin), .out_valid(d16_ov), .out_ready(d16_or),
    .op2(d16_op2), .c_out(d16_c), .out_err(d16_e));

  shifter_operand_pipe #(.DATA_W(64), .STAGES(2)) u_d64 (
    .clk(clk), .reset(reset), .in_valid(d64_iv), .in_ready(d64_ir), .instr(instr),
    .rm_val(rm64), .rs_val(rs), .c_in(cin), .out_valid(d64_ov), .out_ready(d64_or),
    .op2(d64_op2), .c_out(d64_c), .out_err(d64_e));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic op32(input string tag, input logic [31:0] ins, input logic [31:0] rm,
                      input logic [7:0] rsv, input logic ci, input logic [31:0] eo,
                      input logic ec, input logic ee);
    int la, lb;
    logic [31:0] oa, ob;
    logic [1:0]  fa, fb;
    la = 0; lb = 0; oa = '0; ob = '0; fa = '0; fb = '0;
    @(negedge clk);
    instr = ins; rm32 = rm; rs = rsv; cin = ci; d1_iv = 1'b1; d2_iv = 1'b1;
    #1 check($sformatf("%s ready32", tag), {d1_ir, d2_ir}, 2'b11);
    @(posedge clk);
    #1 d1_iv = 1'b0; d2_iv = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (d1_ov && la == 0) begin la = k; oa = d1_op2; fa = {d1_c, d1_e}; end
      if (d2_ov && lb == 0) begin lb = k; ob = d2_op2; fb = {d2_c, d2_e}; end
    end
    check($sformatf("%s s1 latency", tag), la, 1);
    check($sformatf("%s s1 op2", tag), oa, eo);
    check($sformatf("%s s1 c/err", tag), fa, {ec, ee});
    check($sformatf("%s s2 latency", tag), lb, 2);
    check($sformatf("%s s2 op2", tag), ob, eo);
    check($sformatf("%s s2 c/err", tag), fb, {ec, ee});
  endtask

  task automatic op16(input string tag, input logic [31:0] ins, input logic [15:0] rm,
                      input logic [7:0] rsv, input logic ci, input logic [15:0] eo,
                      input logic ec, input logic ee);
    int la;
    logic [15:0] oa;
    logic [1:0]  fa;
    la = 0; oa = '0; fa = '0;
    @(negedge clk);
    instr = ins; rm16 = rm; rs = rsv; cin = ci; d16_iv = 1'b1;
    #1 check($sformatf("%s ready16", tag), d16_ir, 1'b1);
    @(posedge clk);
    #1 d16_iv = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (d16_ov && la == 0) begin la = k; oa = d16_op2; fa = {d16_c, d16_e}; end
    end
    check($sformatf("%s w16 latency", tag), la, 1);
    check($sformatf("%s w16 op2", tag), oa, eo);
    check($sformatf("%s w16 c/err", tag), fa, {ec, ee});
  endtask

  task automatic op64(input string tag, input logic [31:0] ins, input logic [63:0] rm,
                      input logic [7:0] rsv, input logic ci, input logic [63:0] eo,
                      input logic ec, input logic ee);
    int la;
    logic [63:0] oa;
    logic [1:0]  fa;
    la = 0; oa = '0; fa = '0;
    @(negedge clk);
    instr = ins; rm64 = rm; rs = rsv; cin = ci; d64_iv = 1'b1;
    #1 check($sformatf("%s ready64", tag), d64_ir, 1'b1);
    @(posedge clk);
    #1 d64_iv = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (d64_ov && la == 0) begin la = k; oa = d64_op2; fa = {d64_c, d64_e}; end
    end
    check($sformatf("%s w64 latency", tag), la, 2);
    check($sformatf("%s w64 op2", tag), oa, eo);
    check($sformatf("%s w64 c/err", tag), fa, {ec, ee});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, cons, inflight;
    logic prev_stall;
    logic [31:0] prev_op2;

    reset = 1'b1;
    instr = '0; rs = '0; cin = 1'b0; rm32 = '0; rm16 = '0; rm64 = '0;
    d1_iv = 1'b0; d2_iv = 1'b0; d16_iv = 1'b0; d64_iv = 1'b0;
    d1_or = 1'b1; d2_or = 1'b1; d16_or = 1'b1; d64_or = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset flags d1", {d1_ir, d1_ov, d1_c, d1_e}, 4'b0000);
    check("reset flags d2", {d2_ir, d2_ov, d2_c, d2_e}, 4'b0000);
    check("reset flags d16", {d16_ir, d16_ov, d16_c, d16_e}, 4'b0000);
    check("reset flags d64", {d64_ir, d64_ov, d64_c, d64_e}, 4'b0000);
    check("reset op2 d1", d1_op2, 0);
    check("reset op2 d2", d2_op2, 0);
    check("reset op2 d16", d16_op2, 0);
    check("reset op2 d64", d64_op2, 0);
    reset = 1'b0;

    // 32-bit vectors: name, instr, Rm, Rs, c_in, op2, c, err
    op32("imm rot1 ff",  32'h0200_01FF, 32'h0,          8'd0,  1'b0, 32'hC000_003F, 1'b1, 1'b0);
    op32("imm rot0 05",  32'h0200_0005, 32'h0,          8'd0,  1'b1, 32'h0000_0005, 1'b1, 1'b0);
    op32("imm rot4 ab",  32'h0200_04AB, 32'h0,          8'd0,  1'b0, 32'hAB00_0000, 1'b1, 1'b0);
    op32("lsr #0",       32'h0000_0020, 32'h8000_0000,  8'd0,  1'b0, 32'h0,         1'b1, 1'b0);
    op32("asr #0",       32'h0000_0040, 32'h8000_0000,  8'd0,  1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    op32("rrx",          32'h0000_0060, 32'h0000_0001,  8'd0,  1'b1, 32'h8000_0000, 1'b1, 1'b0);
    op32("ror #4",       32'h0000_0260, 32'h0000_000F,  8'd0,  1'b0, 32'hF000_0000, 1'b1, 1'b0);
    op32("lsl #1",       32'h0000_0080, 32'h8000_0001,  8'd0,  1'b0, 32'h0000_0002, 1'b1, 1'b0);
    op32("reg lsl 32",   32'h0000_0010, 32'h0000_0001,  8'd32, 1'b0, 32'h0,         1'b1, 1'b0);
    op32("reg lsl 33",   32'h0000_0010, 32'h0000_0001,  8'd33, 1'b1, 32'h0,         1'b0, 1'b0);
    op32("reg lsl 0",    32'h0000_0010, 32'h0000_0001,  8'd0,  1'b1, 32'h0000_0001, 1'b1, 1'b0);
    op32("reg ror 32",   32'h0000_0070, 32'h8000_0001,  8'd32, 1'b0, 32'h8000_0001, 1'b1, 1'b0);
    op32("reg lsr 4",    32'h0000_0030, 32'h0000_00F8,  8'd4,  1'b0, 32'h0000_000F, 1'b1, 1'b0);
    op32("reg lsr 32",   32'h0000_0030, 32'h8000_0000,  8'd32, 1'b0, 32'h0,         1'b1, 1'b0);
    op32("reg asr 40",   32'h0000_0050, 32'h8000_0000,  8'd40, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    op32("illegal",      32'h0000_0090, 32'h0000_1234,  8'd5,  1'b1, 32'h0000_1234, 1'b1, 1'b1);

    // 16-bit vectors
    op16("imm rot1 ff",  32'h0200_01FF, 16'h0,    8'd0,  1'b0, 16'hC03F, 1'b1, 1'b0);
    op16("imm rot8 81",  32'h0200_0881, 16'h0,    8'd0,  1'b1, 16'h0081, 1'b0, 1'b0);
    op16("imm rot0 05",  32'h0200_0005, 16'h0,    8'd0,  1'b1, 16'h0005, 1'b1, 1'b0);
    op16("lsr #0",       32'h0000_0020, 16'h8000, 8'd0,  1'b0, 16'h0000, 1'b1, 1'b0);
    op16("asr #0",       32'h0000_0040, 16'h8000, 8'd0,  1'b0, 16'hFFFF, 1'b1, 1'b0);
    op16("rrx",          32'h0000_0060, 16'h0001, 8'd0,  1'b1, 16'h8000, 1'b1, 1'b0);
    op16("ror #4",       32'h0000_0260, 16'h000F, 8'd0,  1'b0, 16'hF000, 1'b1, 1'b0);
    op16("lsl #16",      32'h0000_0800, 16'h0001, 8'd0,  1'b0, 16'h0000, 1'b1, 1'b0);
    op16("lsr #20",      32'h0000_0A20, 16'hFFFF, 8'd0,  1'b1, 16'h0000, 1'b0, 1'b0);
    op16("asr #20",      32'h0000_0A40, 16'h7FFF, 8'd0,  1'b1, 16'h0000, 1'b0, 1'b0);
    op16("ror #20",      32'h0000_0A60, 16'h0018, 8'd0,  1'b0, 16'h8001, 1'b1, 1'b0);
    op16("reg lsl 16",   32'h0000_0010, 16'h0001, 8'd16, 1'b0, 16'h0000, 1'b1, 1'b0);
    op16("reg lsl 17",   32'h0000_0010, 16'h0001, 8'd17, 1'b1, 16'h0000, 1'b0, 1'b0);
    op16("reg lsl 0",    32'h0000_0010, 16'h0001, 8'd0,  1'b1, 16'h0001, 1'b1, 1'b0);
    op16("reg ror 16",   32'h0000_0070, 16'h8001, 8'd16, 1'b0, 16'h8001, 1'b1, 1'b0);
    op16("illegal",      32'h0000_0090, 16'hBEEF, 8'd0,  1'b0, 16'hBEEF, 1'b0, 1'b1);

    // 64-bit vectors
    op64("imm rot1 ff",  32'h0200_01FF, 64'h0,                   8'd0,  1'b0, 64'hC000_0000_0000_003F, 1'b1, 1'b0);
    op64("imm rot0 05",  32'h0200_0005, 64'h0,                   8'd0,  1'b1, 64'h5,                   1'b1, 1'b0);
    op64("lsr #0",       32'h0000_0020, 64'h8000_0000_0000_0000, 8'd0,  1'b0, 64'h0,                   1'b1, 1'b0);
    op64("asr #0",       32'h0000_0040, 64'h8000_0000_0000_0000, 8'd0,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    op64("rrx",          32'h0000_0060, 64'h1,                   8'd0,  1'b1, 64'h8000_0000_0000_0000, 1'b1, 1'b0);
    op64("ror #4",       32'h0000_0260, 64'hF,                   8'd0,  1'b0, 64'hF000_0000_0000_0000, 1'b1, 1'b0);
    op64("lsl #31",      32'h0000_0F80, 64'h1,                   8'd0,  1'b1, 64'h0000_0000_8000_0000, 1'b0, 1'b0);
    op64("reg lsl 64",   32'h0000_0010, 64'h1,                   8'd64, 1'b0, 64'h0,                   1'b1, 1'b0);
    op64("reg lsl 65",   32'h0000_0010, 64'h1,                   8'd65, 1'b1, 64'h0,                   1'b0, 1'b0);
    op64("reg lsl 0",    32'h0000_0010, 64'h1,                   8'd0,  1'b1, 64'h1,                   1'b1, 1'b0);
    op64("reg ror 64",   32'h0000_0070, 64'h8000_0000_0000_0001, 8'd64, 1'b0, 64'h8000_0000_0000_0001, 1'b1, 1'b0);
    op64("reg lsr 63",   32'h0000_0030, 64'h8000_0000_0000_0000, 8'd63, 1'b1, 64'h1,                   1'b0, 1'b0);
    op64("reg asr 70",   32'h0000_0050, 64'h4000_0000_0000_0000, 8'd70, 1'b1, 64'h0,                   1'b0, 1'b0);

    // Streaming with a consumer stall (2-stage, 32-bit). Op k yields imm8 = k*17+3.
    acc = 0; cons = 0; prev_stall = 1'b0; prev_op2 = '0;
    for (int cyc = 1; cyc <= 40 && cons < 6; cyc++) begin
      @(negedge clk);
      d2_or = !(cyc >= 3 && cyc <= 5);
      if (acc < 6) begin
        instr = 32'h0200_0000 | 32'(acc * 17 + 3);
        cin   = 1'b0;
        d2_iv = 1'b1;
      end else begin
        d2_iv = 1'b0;
      end
      #1;
      inflight = acc - cons;
      if (prev_stall) check($sformatf("stall hold c%0d", cyc), {d2_ov, d2_op2}, {1'b1, prev_op2});
      check($sformatf("stream in_ready c%0d", cyc), d2_ir, !(inflight == 2 && !d2_or));
      if (d2_ov && d2_or) begin
        check($sformatf("stream order %0d", cons), {d2_op2, d2_c, d2_e}, {32'(cons * 17 + 3), 2'b00});
        cons++;
      end
      if (d2_iv && d2_ir) acc++;
      prev_stall = d2_ov && !d2_or;
      prev_op2   = d2_op2;
    end
    check("stream accepted", acc, 6);
    check("stream delivered", cons, 6);
    d2_iv = 1'b0;
    d2_or = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("stream no dup %0d", k), d2_ov, 1'b0);
    end

    // Reset while the output holds an operation and stage 1 is full
    d2_or = 1'b0;
    @(negedge clk);
    instr = 32'h0200_0077; cin = 1'b1; d2_iv = 1'b1;
    @(negedge clk);
    instr = 32'h0200_0066;
    @(negedge clk);
    d2_iv = 1'b0;
    check("pre-reset out", {d2_ov, d2_op2, d2_c}, {1'b1, 32'h0000_0077, 1'b1});
    check("pre-reset full", d2_ir, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("async reset out", {d2_ov, d2_op2, d2_c, d2_e}, 35'h0);
    check("async reset ready", d2_ir, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    d2_or = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("post-reset drop %0d", k), d2_ov, 1'b0);
    end
    op32("after reset", 32'h0200_0F01, 32'h0, 8'd0, 1'b0, 32'h0000_0004, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
